// File: rtl/mem_arbiter.sv
// Two-requester (CPU / IOP) arbiter in front of a single-port synchronous RAM.
// The owner keeps the port while it requests; a waiting requester takes over after STARVE_LIMIT denied cycles.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int RESET_OWNER  = 0
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic [16:0] cpu_addr,
    input  logic [3:0]  cpu_wr_en,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,

    input  logic        iop_req,
    input  logic [16:0] iop_addr,
    input  logic [3:0]  iop_wr_en,
    input  logic [31:0] iop_wdata,
    output logic        iop_gnt,
    output logic        iop_rvalid,

    output logic [16:0] mem_address,
    output logic [3:0]  mem_write_en,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic [31:0] mem_rdata,

    output logic        cpu_active
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_OWN = 2'd1,
        IOP_OWN = 2'd2
    } state_t;

    localparam logic [7:0] STARVE_LAST = 8'(STARVE_LIMIT - 1);

    state_t     state_q, state_d;
    state_t     other_state;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       cpu_rvalid_q, cpu_rvalid_d;
    logic       iop_rvalid_q, iop_rvalid_d;
    logic       owner_req, other_req, starved;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = 8'd0;
        other_state = IDLE;
        owner_req   = 1'b0;
        other_req   = 1'b0;

        case (state_q)
            CPU_OWN: begin
                owner_req   = cpu_req;
                other_req   = iop_req;
                other_state = IOP_OWN;
            end
            IOP_OWN: begin
                owner_req   = iop_req;
                other_req   = cpu_req;
                other_state = CPU_OWN;
            end
            default: ;
        endcase

        starved = other_req && (wait_cnt_q == STARVE_LAST);

        case (state_q)
            IDLE: begin
                if (cpu_req && iop_req) begin
                    state_d = (RESET_OWNER != 0) ? CPU_OWN : IOP_OWN;
                end else if (cpu_req) begin
                    state_d = CPU_OWN;
                end else if (iop_req) begin
                    state_d = IOP_OWN;
                end
            end
            default: begin
                if (!owner_req) begin
                    state_d = other_req ? other_state : IDLE;
                end else if (starved) begin
                    state_d = other_state;
                end
            end
        endcase

        // The count only survives while ownership is unchanged and the other side keeps asking.
        if ((state_d == state_q) && (state_q != IDLE) && other_req) begin
            wait_cnt_d = (wait_cnt_q == 8'd255) ? wait_cnt_q : wait_cnt_q + 8'd1;
        end
    end

    assign cpu_gnt = (state_q == CPU_OWN) && cpu_req;
    assign iop_gnt = (state_q == IOP_OWN) && iop_req;

    always_comb begin
        mem_address  = 17'd0;
        mem_write_en = 4'd0;
        mem_data_in  = 32'd0;
        case (state_q)
            CPU_OWN: begin
                mem_address  = cpu_addr;
                mem_data_in  = cpu_wdata;
                mem_write_en = cpu_gnt ? cpu_wr_en : 4'd0;
            end
            IOP_OWN: begin
                mem_address  = iop_addr;
                mem_data_in  = iop_wdata;
                mem_write_en = iop_gnt ? iop_wr_en : 4'd0;
            end
            default: ;
        endcase
    end

    always_comb begin
        cpu_rvalid_d = cpu_gnt && (cpu_wr_en == 4'd0);
        iop_rvalid_d = iop_gnt && (iop_wr_en == 4'd0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wait_cnt_q   <= 8'd0;
            cpu_rvalid_q <= 1'b0;
            iop_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            iop_rvalid_q <= iop_rvalid_d;
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign iop_rvalid = iop_rvalid_q;
    assign mem_rdata  = mem_data_out;
    assign cpu_active = (state_q == CPU_OWN);

endmodule
